// File: rtl/idecode32.sv
// Decode stage: 32x32 register file with writeback mux, plus immediate extension.
// Reads and immediate are combinational; writes land on the rising clock edge; no backpressure.
module idecode32 #(
   parameter bit ZERO_EXT_SLTIU = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] Instruction,
   input  logic [31:0] opcplus4,
   input  logic [31:0] read_data,
   input  logic [31:0] ALU_result,
   input  logic        Jal,
   input  logic        RegWrite,
   input  logic        MemtoReg,
   input  logic        RegDst,
   output logic [31:0] read_data_1,
   output logic [31:0] read_data_2,
   output logic [31:0] Sign_extend
);

   logic [31:0] regs [0:31];
   logic [4:0]  rs, rt, rd;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        we;
   logic [5:0]  opcode;
   logic [15:0] imm;
   logic        zero_ext;

   assign rs     = Instruction[25:21];
   assign rt     = Instruction[20:16];
   assign rd     = Instruction[15:11];
   assign opcode = Instruction[31:26];
   assign imm    = Instruction[15:0];

   // Jal outranks every other writeback select
   always_comb begin
      waddr = rt;
      wdata = ALU_result;
      if (Jal) begin
         waddr = 5'd31;
         wdata = opcplus4;
      end else begin
         if (RegDst)   waddr = rd;
         if (MemtoReg) wdata = read_data;
      end
   end

   assign we = RegWrite | Jal;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'h0000_0000;
      end else if (we && (waddr != 5'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   // $0 is forced here so it reads zero even before the first reset
   assign read_data_1 = (rs == 5'd0) ? 32'h0000_0000 : regs[rs];
   assign read_data_2 = (rt == 5'd0) ? 32'h0000_0000 : regs[rt];

   always_comb begin
      zero_ext = 1'b0;
      case (opcode)
         6'b001100, 6'b001101, 6'b001110: zero_ext = 1'b1;
         6'b001011:                       zero_ext = ZERO_EXT_SLTIU;
         default:                         zero_ext = 1'b0;
      endcase
   end

   assign Sign_extend = zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};

endmodule

// File: tb/tb_idecode32.sv
// Randomised and directed check of idecode32 against a register-array model,
// with one instance per sltiu extension mode sharing the same stimulus.
module tb_idecode32;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] Instruction, opcplus4, read_data, ALU_result;
   logic        Jal, RegWrite, MemtoReg, RegDst;
   logic [31:0] rd1_s, rd2_s, se_s;
   logic [31:0] rd1_z, rd2_z, se_z;

   int total = 0;
   int bad   = 0;
   logic [31:0] model [32];

   always #5 clock = ~clock;

   idecode32 #(.ZERO_EXT_SLTIU(1'b0)) dut_s (
      .clock(clock), .reset(reset), .Instruction(Instruction), .opcplus4(opcplus4),
      .read_data(read_data), .ALU_result(ALU_result), .Jal(Jal), .RegWrite(RegWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst),
      .read_data_1(rd1_s), .read_data_2(rd2_s), .Sign_extend(se_s));

   idecode32 #(.ZERO_EXT_SLTIU(1'b1)) dut_z (
      .clock(clock), .reset(reset), .Instruction(Instruction), .opcplus4(opcplus4),
      .read_data(read_data), .ALU_result(ALU_result), .Jal(Jal), .RegWrite(RegWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst),
      .read_data_1(rd1_z), .read_data_2(rd2_z), .Sign_extend(se_z));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Immediate value from the opcode rules, computed arithmetically
   function automatic logic [31:0] exp_imm(input logic [31:0] ins, input bit zs);
      int op;
      int imm;
      bit zero;
      op   = int'(ins[31:26]);
      imm  = int'(ins[15:0]);
      zero = (op == 12) || (op == 13) || (op == 14) || ((op == 11) && zs);
      if (!zero && imm >= 32768) imm = imm - 65536;
      return 32'(imm);
   endfunction

   function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 11'd0};
   endfunction

   // Drive one cycle: check combinational outputs before the edge, then advance the model
   task automatic step(input logic [31:0] ins, input logic j, input logic rw,
                       input logic m2r, input logic rdst, input logic rst,
                       input logic [31:0] pc4, input logic [31:0] rdat, input logic [31:0] alu);
      int wa;
      logic [31:0] wd;
      @(negedge clock);
      Instruction = ins; Jal = j; RegWrite = rw; MemtoReg = m2r; RegDst = rdst;
      reset = rst; opcplus4 = pc4; read_data = rdat; ALU_result = alu;
      #1;
      check("rd1_s", rd1_s, model[int'(ins[25:21])]);
      check("rd2_s", rd2_s, model[int'(ins[20:16])]);
      check("rd1_z", rd1_z, model[int'(ins[25:21])]);
      check("rd2_z", rd2_z, model[int'(ins[20:16])]);
      check("imm_s", se_s, exp_imm(ins, 1'b0));
      check("imm_z", se_z, exp_imm(ins, 1'b1));
      @(posedge clock);
      wa = j ? 31 : (rdst ? int'(ins[15:11]) : int'(ins[20:16]));
      wd = j ? pc4 : (m2r ? rdat : alu);
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if ((rw || j) && wa != 0) begin
         model[wa] = wd;
      end
   endtask

   // Read a register through rs with writes disabled and compare to a fixed value
   task automatic peek(input string tag, input logic [4:0] r, input logic [31:0] exp);
      @(negedge clock);
      Instruction = mk_r(6'd0, r, r, 5'd0); Jal = 1'b0; RegWrite = 1'b0; reset = 1'b0;
      #1;
      check(tag, rd1_s, exp);
      check(tag, rd2_z, exp);
   endtask

   initial begin
      logic [5:0]  ops [8];
      logic [5:0]  op;
      logic [31:0] ins;
      ops = '{6'b001100, 6'b001101, 6'b001110, 6'b001011, 6'b001000, 6'b100011, 6'b000000, 6'b000100};

      Instruction = 32'h0; opcplus4 = 32'h0; read_data = 32'h0; ALU_result = 32'h0;
      Jal = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0; RegDst = 1'b0; reset = 1'b1;
      @(posedge clock);
      for (int i = 0; i < 32; i++) model[i] = 32'h0;

      // every rs/rt pair reads zero after reset
      for (int i = 0; i < 32; i++)
         step(mk_r(6'd0, 5'(i), 5'(31 - i), 5'd0), 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);

      // write $5 via rd: old value before the edge, new value after
      step(mk_r(6'd0, 5'd5, 5'd6, 5'd5), 0, 1, 0, 1, 0, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678);
      peek("r5_after", 5'd5, 32'h1234_5678);

      // Jal wins over RegDst/MemtoReg; rd ($5) and rt ($6) untouched
      step(mk_r(6'd0, 5'd31, 5'd6, 5'd5), 1, 0, 1, 1, 0, 32'h0000_0104, 32'hCAFE_0000, 32'h7777_7777);
      peek("r31_jal", 5'd31, 32'h0000_0104);
      peek("r5_keep", 5'd5, 32'h1234_5678);
      peek("r6_keep", 5'd6, 32'h0000_0000);

      // writes to $0 are dropped
      step(mk_r(6'd0, 5'd0, 5'd0, 5'd0), 0, 1, 0, 1, 0, 32'h0, 32'h0, 32'hFFFF_FFFF);
      step(mk_r(6'd0, 5'd0, 5'd0, 5'd0), 0, 1, 1, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'h0);
      peek("r0_zero", 5'd0, 32'h0000_0000);

      // immediate extension boundaries
      step({6'b001101, 5'd0, 5'd0, 16'h8001}, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      check("ori_imm", se_s, 32'h0000_8001);
      step({6'b001000, 5'd0, 5'd0, 16'h8001}, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      check("addi_imm", se_z, 32'hFFFF_8001);
      step({6'b001011, 5'd0, 5'd0, 16'h8001}, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      check("sltiu_sx", se_s, 32'hFFFF_8001);
      check("sltiu_zx", se_z, 32'h0000_8001);

      // reset beats a same-cycle write
      step({6'b001000, 5'd7, 5'd7, 16'h0}, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'hA5A5_A5A5);
      peek("r7_set", 5'd7, 32'hA5A5_A5A5);
      step({6'b001000, 5'd7, 5'd7, 16'h0}, 0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h0000_0001);
      peek("r7_reset", 5'd7, 32'h0000_0000);
      peek("r31_reset", 5'd31, 32'h0000_0000);

      // random traffic with occasional resets
      for (int n = 0; n < 600; n++) begin
         op  = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 7)] : 6'($urandom);
         ins = {op, 26'($urandom)};
         step(ins, ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 59) == 0), $urandom, $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
